ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//  to the keyboard over the same open-drain clk/data pair the existing PS/2 receive path listens on.
//  Runs on the system clock, synchronises the device-driven PS/2 clock, frames start/8 data LSB-first/
//  odd parity/stop, checks the device ACK. Receive path must ignore the bus while tx_busy=1.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency
//  INHIBIT_CYCLES  6000        cycles PS/2 clock held low before request-to-send (>=100 us at CLK_HZ)
//  TIMEOUT_CYCLES  750_000     max cycles between device clock falling edges before abort (15 ms)
// PORTS
//  clk                 in   1  system clock, all logic on posedge
//  rst_n               in   1  synchronous active-low reset
//  tx_data             in   8  command byte, captured on accept
//  tx_valid            in   1  request to send tx_data
//  tx_ready            out  1  high only in IDLE; accept = tx_valid & tx_ready
//  tx_busy             out  1  high from accept until return to IDLE
//  tx_done             out  1  one-cycle pulse: frame sent, ACK received
//  tx_err              out  1  one-cycle pulse: NACK or timeout
//  ps2_clk_in          in   1  raw PS/2 clock line (async)
//  ps2_data_in         in   1  raw PS/2 data line (async)
//  ps2_clk_drive_low   out  1  1 = pull PS/2 clock low, 0 = release (pad is open-drain)
//  ps2_data_drive_low  out  1  1 = pull PS/2 data low, 0 = release
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): state IDLE, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0,
//    both drive_low=0, counters cleared; applies mid-frame and releases the bus next edge.
//  - ps2_clk_in/ps2_data_in pass 2-FF synchronisers; fall = prev_sync=1 & cur_sync=0 (1 clk pulse).
//  - Frame shift reg {stop=1, parity=~^tx_data, tx_data[7:0]} loaded on accept; parity odd.
//  - States:
//    IDLE:    tx_ready=1. On accept -> INHIBIT next cycle, clk_drive_low=1, cycle ctr=0.
//    INHIBIT: hold clock low INHIBIT_CYCLES; at terminal count data_drive_low=1 (start bit) and
//             one cycle later clk_drive_low=0 -> REQ. Data goes low while clock still low.
//    REQ:     wait device fall #1; on it drive bit0 -> SHIFT, bit ctr=1.
//    SHIFT:   each fall drives next frame bit (data_drive_low = ~bit): falls 2..8 bits1..7,
//             fall 9 parity, fall 10 stop (data released) -> ACK.
//    ACK:     on fall 11 sample data_sync: 0 -> WAIT_IDLE; 1 -> NACK error.
//    WAIT_IDLE: wait clk_sync=1 & data_sync=1 simultaneously, then tx_done pulse, -> IDLE.
//  - Data changes only in the system cycle after a detected fall (device samples on rise).
//  - Timeout: in REQ/SHIFT/ACK/WAIT_IDLE, TIMEOUT_CYCLES without a fall (WAIT_IDLE: without idle bus)
//    -> both drives released, tx_err pulse, IDLE. Timeout ctr reloads on every fall.
//  - tx_valid while busy is ignored (no queue); tx_data changes after accept have no effect.
//  - tx_done and tx_err never both high; exactly one of them per accepted frame.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on first NACK/timeout of a frame, release bus, re-enter INHIBIT with the
//    same byte (one retry); tx_err pulses only if the retry also fails; tx_busy stays high throughout.
//  Undefined: first NACK/timeout pulses tx_err and returns to IDLE.
// TESTING (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks at 1/50 clk)
//  1 send 0xED -> data bits 1,0,1,1,0,1,1,1 on falls 1-8, parity 1, stop released, ACK 0 -> tx_done once.
//  2 send 0x01 -> parity bit 0; send 0x00 -> parity 1; model checks odd parity and bit order.
//  3 accept 0xFF, model asserts no clock before INHIBIT end; clk_drive_low held exactly 20+1 cycles.
//  4 model leaves data high at fall 11 -> tx_err pulse, no tx_done, both drives 0 (retry: second frame seen).
//  5 model stops clocking after fall 4 -> tx_err after 2000 cycles, bus released, tx_ready=1.
//  6 rst_n=0 during SHIFT bit 5 -> next edge drives=0, tx_ready=1; tx_valid during busy ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, and shifts out start/8 data LSB-first/odd parity/stop
// on device clock falls. It then checks the device ACK and waits for an idle bus.
// Optional build macro: PS2_TX_RETRY_EN enables one automatic retry of a failed frame.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    // Never inhibit for less than 100 us, whatever INHIBIT_CYCLES says.
    localparam int INHIBIT_MIN = CLK_HZ / 10_000;
    localparam int INHIBIT_EFF = (INHIBIT_CYCLES > INHIBIT_MIN) ? INHIBIT_CYCLES : INHIBIT_MIN;
    localparam int INH_W       = $clog2(INHIBIT_EFF + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_EFF);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_EFF - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Frame after the start bit: {stop, odd parity, data}; bit 0 goes out first.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        frame_of = {1'b1, ~^b, b};
    endfunction

    state_t             state_r, state_nxt;
    logic               clk_s1_r, clk_s2_r, clk_prev_r, data_s1_r, data_s2_r;
    logic               clk_fall_s, accept_s, abort_s;
    logic [9:0]         shift_r, shift_nxt;
    logic [INH_W-1:0]   inh_ctr_r, inh_ctr_nxt;
    logic [3:0]         bit_ctr_r, bit_ctr_nxt;
    logic [TO_W-1:0]    to_ctr_r, to_ctr_nxt;
    logic               clk_drive_r, clk_drive_nxt, data_drive_r, data_drive_nxt;
    logic               done_r, done_nxt, err_r, err_nxt;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]         byte_r, byte_nxt;
    logic               retry_used_r, retry_used_nxt;
`endif

    assign clk_fall_s         = clk_prev_r & ~clk_s2_r;
    assign accept_s           = tx_valid & (state_r == ST_IDLE);
    assign tx_ready           = (state_r == ST_IDLE);
    assign tx_busy            = (state_r != ST_IDLE);
    assign tx_done            = done_r;
    assign tx_err             = err_r;
    assign ps2_clk_drive_low  = clk_drive_r;
    assign ps2_data_drive_low = data_drive_r;

    // Two-flop synchronisers for the device-driven lines plus the fall-edge history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_r   <= 1'b1;
            clk_s2_r   <= 1'b1;
            clk_prev_r <= 1'b1;
            data_s1_r  <= 1'b1;
            data_s2_r  <= 1'b1;
        end else begin
            clk_s1_r   <= ps2_clk_in;
            clk_s2_r   <= clk_s1_r;
            clk_prev_r <= clk_s2_r;
            data_s1_r  <= ps2_data_in;
            data_s2_r  <= data_s1_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shift_r      <= 10'd0;
            inh_ctr_r    <= '0;
            bit_ctr_r    <= 4'd0;
            to_ctr_r     <= '0;
            clk_drive_r  <= 1'b0;
            data_drive_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            byte_r       <= 8'd0;
            retry_used_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt;
            shift_r      <= shift_nxt;
            inh_ctr_r    <= inh_ctr_nxt;
            bit_ctr_r    <= bit_ctr_nxt;
            to_ctr_r     <= to_ctr_nxt;
            clk_drive_r  <= clk_drive_nxt;
            data_drive_r <= data_drive_nxt;
            done_r       <= done_nxt;
            err_r        <= err_nxt;
`ifdef PS2_TX_RETRY_EN
            byte_r       <= byte_nxt;
            retry_used_r <= retry_used_nxt;
`endif
        end
    end

    // Next-state and next-output logic; bus drive changes only in the cycle after a detected fall.
    always_comb begin
        state_nxt      = state_r;
        shift_nxt      = shift_r;
        inh_ctr_nxt    = inh_ctr_r;
        bit_ctr_nxt    = bit_ctr_r;
        to_ctr_nxt     = to_ctr_r;
        clk_drive_nxt  = clk_drive_r;
        data_drive_nxt = data_drive_r;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        abort_s        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_nxt       = byte_r;
        retry_used_nxt = retry_used_r;
`endif
        case (state_r)
            ST_IDLE: begin
                clk_drive_nxt  = 1'b0;
                data_drive_nxt = 1'b0;
                if (accept_s) begin
                    state_nxt     = ST_INHIBIT;
                    shift_nxt     = frame_of(tx_data);
                    inh_ctr_nxt   = '0;
                    clk_drive_nxt = 1'b1;
`ifdef PS2_TX_RETRY_EN
                    byte_nxt       = tx_data;
                    retry_used_nxt = 1'b0;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                clk_drive_nxt = 1'b1;
                if (inh_ctr_r == INH_LAST) begin
                    // Start bit is already on the data line; releasing the clock is the request-to-send.
                    clk_drive_nxt = 1'b0;
                    state_nxt     = ST_REQ;
                    to_ctr_nxt    = '0;
                end else begin
                    if (inh_ctr_r == INH_START) begin
                        data_drive_nxt = 1'b1;
                    end else begin
                        data_drive_nxt = data_drive_r;
                    end
                    inh_ctr_nxt = inh_ctr_r + INH_W'(1);
                end
            end
            ST_REQ, ST_SHIFT: begin
                if (clk_fall_s) begin
                    data_drive_nxt = ~shift_r[0];
                    shift_nxt      = {1'b1, shift_r[9:1]};
                    to_ctr_nxt     = '0;
                    if (state_r == ST_REQ) begin
                        bit_ctr_nxt = 4'd1;
                        state_nxt   = ST_SHIFT;
                    end else if (bit_ctr_r == 4'd9) begin
                        // Fall 10 puts the stop bit (released line) out; next fall is the ACK.
                        bit_ctr_nxt = 4'd10;
                        state_nxt   = ST_ACK;
                    end else begin
                        bit_ctr_nxt = bit_ctr_r + 4'd1;
                    end
                end else if (to_ctr_r == TO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    to_ctr_nxt = to_ctr_r + TO_W'(1);
                end
            end
            ST_ACK: begin
                if (clk_fall_s) begin
                    to_ctr_nxt = '0;
                    if (data_s2_r) begin
                        abort_s = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT_IDLE;
                    end
                end else if (to_ctr_r == TO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    to_ctr_nxt = to_ctr_r + TO_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s2_r && data_s2_r) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (clk_fall_s) begin
                    to_ctr_nxt = '0;
                end else if (to_ctr_r == TO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    to_ctr_nxt = to_ctr_r + TO_W'(1);
                end
            end
            default: begin
                state_nxt      = ST_IDLE;
                clk_drive_nxt  = 1'b0;
                data_drive_nxt = 1'b0;
            end
        endcase

        if (abort_s) begin
            clk_drive_nxt  = 1'b0;
            data_drive_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_used_r) begin
                retry_used_nxt = 1'b1;
                state_nxt      = ST_INHIBIT;
                shift_nxt      = frame_of(byte_r);
                inh_ctr_nxt    = '0;
                clk_drive_nxt  = 1'b1;
            end else begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
`else
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
`endif
        end else begin
            err_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device clocking at 1/50 of clk.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ(200_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, frame_cnt = 0;
    int   err_cyc = 0, last_fall_cyc = 0;
    logic cdl_prev = 1'b0;

    // Pulse counters, frame-start counter and cycle stamp.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk_drive_low === 1'b1 && cdl_prev === 1'b0) frame_cnt <= frame_cnt + 1;
        cdl_prev <= ps2_clk_drive_low;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_busy", tx_busy, 1);
    endtask

    // Device side: wait for inhibit + RTS, then clock out up to 11 pulses, sampling on rises.
    task automatic device_frame(input int stop_after, input logic nack, input logic poke,
                                output logic [7:0] dbits, output logic par, output logic stopb,
                                output logic start_low, output int inh_len, output logic ok);
        int n;
        dbits = 8'h00; par = 1'b0; stopb = 1'b0; start_low = 1'b0; inh_len = 0; ok = 1'b0;
        n = 0;
        while (ps2_clk_drive_low !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) return;
        while (ps2_clk_drive_low === 1'b1 && inh_len < 500) begin
            inh_len++;
            @(negedge clk);
        end
        start_low = (ps2_data_line == 1'b0);
        ok = (inh_len < 500);
        tick(10);
        for (int i = 1; i <= 11; i++) begin
            if (i <= stop_after) begin
                if (poke && i == 3) begin
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                end
                dev_clk_low   = 1'b1;
                last_fall_cyc = cyc;
                tick(25);
                if (i <= 8) dbits[i-1] = ps2_data_line;
                else if (i == 9) par = ps2_data_line;
                else if (i == 10) stopb = ps2_data_line;
                tx_valid    = 1'b0;
                dev_clk_low = 1'b0;
                if (i == 10) begin
                    tick(10);
                    dev_data_low = ~nack;
                    tick(15);
                end else begin
                    tick(25);
                end
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, input int bound);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("end_of_frame_bound", 0, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic       poke;
        logic [7:0] exp_byte;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
        int         exp_frames;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] bits;
    logic       par, stopb, start_low, ok;
    int         inh_len, d0, e0, f0, lat;

    initial begin
        vecs[0] = '{8'hED, 1'b0, 1'b0, 8'hED, 1'b1, 1, 0, 1};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1, 0, 1};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1, 0, 1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1, 0, 1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 0, 1};
`ifdef PS2_TX_RETRY_EN
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1, 2};
`else
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1, 1};
`endif

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_pulses", {tx_done, tx_err}, 0);
        check("reset_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        rst_n = 1'b1;
        tick(2);

        for (int k = 0; k < 6; k++) begin
            d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
            send(vecs[k].data);
            device_frame(11, vecs[k].nack, vecs[k].poke, bits, par, stopb, start_low, inh_len, ok);
            check("rts_seen", ok, 1);
            check("inhibit_len", inh_len, INH + 1);
            check("start_bit_low", start_low, 1);
            check("data_bits", bits, vecs[k].exp_byte);
            check("parity_bit", par, vecs[k].exp_par);
            check("stop_bit", stopb, 1);
            wait_end(d0, e0, 6000);
            tick(3);
            check("done_count", done_cnt - d0, vecs[k].exp_done);
            check("err_count", err_cnt - e0, vecs[k].exp_err);
            check("frames_started", frame_cnt - f0, vecs[k].exp_frames);
            check("drives_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
            check("ready_after", tx_ready, 1);
        end

        // Device stops clocking after fall 4: timeout abort.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h12);
        device_frame(4, 1'b0, 1'b0, bits, par, stopb, start_low, inh_len, ok);
        wait_end(d0, e0, 6000);
        tick(3);
        lat = err_cyc - last_fall_cyc;
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
`ifdef PS2_TX_RETRY_EN
        check("timeout_latency", (lat >= 4010 && lat <= 4040) ? 1 : 0, 1);
`else
        check("timeout_latency", (lat >= 1990 && lat <= 2015) ? 1 : 0, 1);
`endif
        check("timeout_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("timeout_ready", tx_ready, 1);

        // Reset in the middle of SHIFT (after fall 5).
        d0 = done_cnt; e0 = err_cnt;
        send(8'h9C);
        device_frame(5, 1'b0, 1'b0, bits, par, stopb, start_low, inh_len, ok);
        check("pre_reset_busy", tx_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("midreset_ready", tx_ready, 1);
        check("midreset_busy", tx_busy, 0);
        rst_n = 1'b1;
        tick(3);
        check("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        // Recovery frame after reset.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        device_frame(11, 1'b0, 1'b0, bits, par, stopb, start_low, inh_len, ok);
        check("recover_bits", bits, 8'hED);
        wait_end(d0, e0, 6000);
        tick(3);
        check("recover_done", done_cnt - d0, 1);
        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
